// File: rtl/led_pattern_gen.sv
// LED pattern animator: plays one of four 3-LED patterns, one step per 1 s tick.
// It restarts on every load and pulses wrap each time a pattern period completes.
module led_pattern_gen #(
    parameter int LED_W      = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             delay_1s,
    input  logic             led_load_en,
    input  logic [1:0]       led_sel,
    output logic [LED_W-1:0] led,
    output logic [1:0]       cur_sel,
    output logic             wrap
);

    localparam logic [1:0] SEL_OFF   = 2'd0;
    localparam logic [1:0] SEL_RUN   = 2'd1;
    localparam logic [1:0] SEL_BLINK = 2'd2;
    localparam logic [1:0] SEL_COUNT = 2'd3;

    logic [2:0]       step;
    logic [2:0]       step_next;
    logic [LED_W-1:0] pat;

    // Last valid step index of each pattern (period - 1).
    function automatic logic [2:0] last_step(input logic [1:0] sel);
        case (sel)
            SEL_OFF:   last_step = 3'd0;
            SEL_RUN:   last_step = 3'd2;
            SEL_BLINK: last_step = 3'd1;
            default:   last_step = 3'd7;
        endcase
    endfunction

    // Logical LED vector (1 = lit) for a given pattern and step.
    function automatic logic [LED_W-1:0] pattern(input logic [1:0] sel, input logic [2:0] s);
        case (sel)
            SEL_OFF:   pattern = '0;
            SEL_RUN:   pattern = LED_W'(1) << s;
            SEL_BLINK: pattern = (s == 3'd0) ? {LED_W{1'b1}} : '0;
            SEL_COUNT: pattern = LED_W'(s);
            default:   pattern = '0;
        endcase
    endfunction

    always_comb begin
        step_next = (step == last_step(cur_sel)) ? 3'd0 : step + 3'd1;
    end

    // Load has priority over a coincident tick; reset has priority over both.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cur_sel <= SEL_RUN;
            step    <= 3'd0;
            pat     <= pattern(SEL_RUN, 3'd0);
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (led_load_en) begin
                cur_sel <= led_sel;
                step    <= 3'd0;
                pat     <= pattern(led_sel, 3'd0);
            end else if (delay_1s) begin
                step <= step_next;
                pat  <= pattern(cur_sel, step_next);
                wrap <= (step_next == 3'd0);
            end
        end
    end

    assign led = ACTIVE_LOW ? ~pat : pat;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a table-driven model predicts each cycle's
// outputs, a driver queues them, and a monitor compares after every clock edge.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       delay_1s = 1'b0;
    logic       led_load_en = 1'b0;
    logic [1:0] led_sel = 2'd0;
    logic [2:0] led;
    logic [1:0] cur_sel;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(.LED_W(3), .ACTIVE_LOW(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .delay_1s    (delay_1s),
        .led_load_en (led_load_en),
        .led_sel     (led_sel),
        .led         (led),
        .cur_sel     (cur_sel),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: each pattern is a literal list of lit-LED vectors.
    int unsigned seq_tab [4][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 2, 4, 0, 0, 0, 0, 0},
        '{7, 0, 0, 0, 0, 0, 0, 0},
        '{0, 1, 2, 3, 4, 5, 6, 7}
    };
    int unsigned seq_len [4] = '{1, 3, 2, 8};

    int unsigned m_sel  = 1;
    int unsigned m_pos  = 0;
    bit          m_wrap = 1'b0;

    typedef struct packed {
        logic [2:0] led;
        logic [1:0] sel;
        logic       wrap;
    } exp_t;

    exp_t exp_q [$];

    task automatic check(input string name, input exp_t actual, input exp_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got led=%b cur_sel=%0d wrap=%b, expected led=%b cur_sel=%0d wrap=%b",
                     name, actual.led, actual.sel, actual.wrap,
                     expected.led, expected.sel, expected.wrap);
        end
    endtask

    // Apply one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic drive(input bit r, input bit t, input bit l, input int unsigned s);
        exp_t e;
        @(negedge clk);
        rst_n       = r;
        delay_1s    = t;
        led_load_en = l;
        led_sel     = 2'(s);
        if (!r) begin
            m_sel = 1; m_pos = 0; m_wrap = 1'b0;
        end else if (l) begin
            m_sel = s; m_pos = 0; m_wrap = 1'b0;
        end else if (t) begin
            m_pos  = (m_pos + 1) % seq_len[m_sel];
            m_wrap = (m_pos == 0);
        end else begin
            m_wrap = 1'b0;
        end
        e.led  = ~3'(seq_tab[m_sel][m_pos]);
        e.sel  = 2'(m_sel);
        e.wrap = m_wrap;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 1, 0, 0);
            drive(1, 0, 0, 0);
        end
    endtask

    // Monitor: outputs are presented every cycle, so pop one expectation per edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t act;
            act.led  = led;
            act.sel  = cur_sel;
            act.wrap = wrap;
            check("cycle_outputs", act, exp_q.pop_front());
        end
    end

    initial begin
        // Reset, then free-running RUN pattern.
        drive(0, 0, 0, 0);
        drive(0, 1, 1, 3);
        idle(2);
        ticks(3);

        // COUNT through a full period and one more step.
        drive(1, 0, 1, 3);
        ticks(9);

        // BLINK for two periods.
        drive(1, 0, 1, 2);
        ticks(4);

        // Load and tick together while in COUNT at step 5.
        drive(1, 0, 1, 3);
        ticks(5);
        drive(1, 1, 1, 1);
        idle(2);

        // Reset with a coincident tick while in BLINK at step 1.
        drive(1, 0, 1, 2);
        ticks(1);
        drive(0, 1, 0, 0);
        ticks(1);

        // OFF: every tick wraps.
        drive(1, 0, 1, 0);
        ticks(3);

        // Back-to-back loads, then ticks held high for several cycles.
        drive(1, 0, 1, 3);
        drive(1, 0, 1, 2);
        drive(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(49) != 0), ($urandom_range(2) == 0),
                  ($urandom_range(7) == 0), $urandom_range(3));
        end
        idle(2);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Downstream LED stage of the bare-metal FPGA demo. It consumes the 2-bit pattern select and its load strobe produced by the top-level RAM playback logic, plus the 1 s tick from the clock divider. It animates the selected pattern on the 3 board LEDs, advancing one step per tick. It also flags each completed pattern period so the upstream sequencer or a debug probe can observe progress.

## Interface
- `LED_W`, 3: LED count; fixed at 3 for this board, and the patterns below are defined for 3.
- `ACTIVE_LOW`, 1: 1 means `led` pins are driven inverted (board LEDs sink current); 0 means true polarity.

- `clk` input 1: main clock (`clk_main` domain). One clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `delay_1s` input 1: 1 s tick, a single-cycle high pulse; each high cycle counts as one tick.
- `led_load_en` input 1: load strobe; captures `led_sel` this cycle.
- `led_sel` input 2: pattern select, sampled only when `led_load_en` = 1.
- `led` output LED_W: registered LED pins, with polarity per `ACTIVE_LOW`.
- `cur_sel` output 2: currently active pattern.
- `wrap` output 1: one-cycle pulse when a tick returns the pattern to step 0.

## Operation
- Internal state:
  - `cur_sel` register (2 b).
  - `step` counter (3 b).
  - logical LED vector `pat` (3 b), where 1 means lit.
  - Output: `led = ACTIVE_LOW ? ~pat : pat`.
- Patterns, with `pat` as a function of `cur_sel` and `step`:
  - 0 OFF: `pat` = 000; period 1 (step is always 0).
  - 1 RUN: one-hot; step 0/1/2 gives 001/010/100; period 3.
  - 2 BLINK: step 0 gives 111, step 1 gives 000; period 2.
  - 3 COUNT: `pat` = step (000 to 111); period 8.
- Load: when `led_load_en` = 1:
  - `cur_sel` ← `led_sel`.
  - `step` ← 0.
  - `pat` ← step-0 value of the new pattern.
  - This applies even when `led_sel` equals the current `cur_sel`, so the pattern restarts.
- Tick: when `delay_1s` = 1 and `led_load_en` = 0:
  - `step` ← (step == period−1) ? 0 : step+1.
  - `pat` ← value for the new step.
  - `wrap` ← 1 iff the new step is 0.
  - For OFF, every tick raises `wrap`.
- Neither load nor tick: all state holds, and `wrap` ← 0.
- Load and tick in the same cycle: load wins, the tick is discarded, and `wrap` = 0.
- `step` is never outside 0..period−1 for the active pattern; a load always resets it, so there are no stale out-of-range values.

## Timing
- All outputs are registered. `led`, `cur_sel` and `wrap` change on the clock edge after the cycle in which load or tick is sampled (1-cycle latency).
- Reset (`rst_n` = 0 at a rising edge), with sync reset taking priority over load and tick:
  - `cur_sel` = 1 (RUN).
  - `step` = 0.
  - `pat` = 001, so `led` = 110 when ACTIVE_LOW = 1 (001 when ACTIVE_LOW = 0).
  - `wrap` = 0.
- Reset asserted mid-pattern: the state returns to the reset values on the next edge, and ticks or loads during reset are ignored.
- There is no handshake. `led_load_en` is a fire-and-forget pulse and the block never stalls upstream.
- Back-to-back loads on consecutive cycles: the last one wins, and each load restarts at step 0.
- `delay_1s` held high for N cycles counts as N ticks (upstream guarantees single-cycle pulses).

## Test plan
- Reset, then release with no load:
  - `led` = 110, `cur_sel` = 1.
  - 3 ticks give `pat` 010, 100, 001, with `wrap` high only on the third tick's following cycle.
- Load `led_sel` = 3, then 9 ticks:
  - `pat` steps 000 (at load), then 001..111, then 000.
  - `wrap` pulses exactly once, on the 8th tick.
  - The 9th tick gives `pat` = 001.
- Load `led_sel` = 2, then 4 ticks:
  - `pat` is 111 at load, then 000, 111, 000, 111.
  - `wrap` pulses on ticks 2 and 4.
- Load and tick in the same cycle with `led_sel` = 1 while in COUNT at step 5:
  - Next cycle: `cur_sel` = 1, `pat` = 001, `wrap` = 0.
  - Step is not advanced.
- Assert `rst_n` = 0 for one cycle while in BLINK at step 1, with a tick coincident:
  - `led` = 110, `cur_sel` = 1, `wrap` = 0.
  - The following tick gives `pat` = 010.
- Load `led_sel` = 0 and tick 3 times:
  - `pat` stays 000 and `led` = 111 (ACTIVE_LOW = 1).
  - `wrap` pulses after every tick.
